dmem_resp: RTL

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_resp.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the dmem_resp data-memory responder.
//   state_e   - access sequencer states
//   DBG_ADDR  - memory-mapped debug register address (DMEM_MMIO_EN builds)
//   CYC_ADDR  - memory-mapped free-running cycle counter address (DMEM_MMIO_EN builds)
//   CNT_W     - width of the wait-cycle down-counter (WAIT_CYCLES <= 15)
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] DBG_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] CYC_ADDR = 32'hFFFF_FFF4;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: plain word storage, synchronous write, asynchronous read.
// No reset: contents survive rst.
// Ports:
//   clk      - clock, write on rising edge
//   we_i     - write enable
//   addr_i   - word index (shared by read and write)
//   wdata_i  - write data
//   rdata_o  - combinational read data at addr_i
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: M-stage data-memory responder with a fixed per-access stall.
// Each load/store stalls the pipeline for exactly WAIT_CYCLES cycles; the
// access itself happens at the edge entering DONE, where load data is
// registered and returned for one cycle. WAIT_CYCLES=0 bypasses the
// sequencer entirely (combinational load, store at end of request cycle).
//
// Optional feature: define DMEM_MMIO_EN to map a debug register at DBG_ADDR
// (drives DbgOutM) and a read-only free-running cycle counter at CYC_ADDR.
// Without it DbgOutM is 0 and those addresses alias into the array.
//
// Ports:
//   clk         - clock
//   reset       - asynchronous active-low reset
//   MemReadM    - load request
//   MemWriteM   - store request (wins over MemReadM)
//   ALUOutM     - byte address
//   WriteDataM  - store data
//   ReadDataM   - load data (0 when no load is being returned)
//   StallM      - pipeline freeze
//   MemErrM     - one-cycle misalignment flag
//   DbgOutM     - debug register output
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a request; request cycle counts as a stall cycle
// WAIT    | remaining stall cycles, cnt_q counts down to 0
// DONE    | access performed at entry edge; load data presented, no stall
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MemErrM,
  output logic [31:0] DbgOutM
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CNT_INIT_I = (WAIT_CYCLES >= 2) ? WAIT_CYCLES - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_INIT_I[CNT_W-1:0];
  // With 0 or 1 wait cycles the access edge is the request edge itself, so
  // the live inputs are used; otherwise the request captured at accept is.
  localparam bit LIVE = (WAIT_CYCLES < 2);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic        req;
  logic        fire;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_we;
  logic        acc_misal;
  logic        acc_mmio;
  logic        arr_we;
  logic [31:0] arr_rdata;
  logic [31:0] load_val;

  assign req       = MemReadM | MemWriteM;
  assign acc_addr  = LIVE ? ALUOutM    : addr_q;
  assign acc_wdata = LIVE ? WriteDataM : wdata_q;
  assign acc_we    = LIVE ? MemWriteM  : we_q;
  assign acc_misal = |acc_addr[1:0];

  // fire marks the cycle whose closing edge performs the access.
  always_comb begin
    fire = 1'b0;
    if (WAIT_CYCLES == 0)      fire = req;
    else if (WAIT_CYCLES == 1) fire = (state_q == ST_IDLE) && req;
    else                       fire = (state_q == ST_WAIT) && (cnt_q == '0);
  end

  assign arr_we = reset && fire && acc_we && !acc_misal && !acc_mmio;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .addr_i  (acc_addr[AW+1:2]),
    .wdata_i (acc_wdata),
    .rdata_o (arr_rdata)
  );

`ifdef DMEM_MMIO_EN
  logic [31:0] dbg_q;
  logic [31:0] cyc_q;
  logic        acc_dbg;
  logic        acc_cyc;

  assign acc_dbg  = (acc_addr == DBG_ADDR);
  assign acc_cyc  = (acc_addr == CYC_ADDR);
  assign acc_mmio = acc_dbg | acc_cyc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_q <= '0;
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (fire && acc_we && acc_dbg) dbg_q <= acc_wdata;
    end
  end

  assign DbgOutM = dbg_q;
`else
  logic unused_addr_hi;

  assign acc_mmio       = 1'b0;
  assign DbgOutM        = '0;
  assign unused_addr_hi = ^acc_addr[31:AW+2];
`endif

  always_comb begin
    load_val = arr_rdata;
`ifdef DMEM_MMIO_EN
    if (acc_dbg)      load_val = dbg_q;
    else if (acc_cyc) load_val = cyc_q;
`endif
    if (acc_misal || acc_we) load_val = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req && (WAIT_CYCLES != 0)) begin
            addr_q  <= ALUOutM;
            wdata_q <= WriteDataM;
            we_q    <= MemWriteM;
            if (WAIT_CYCLES == 1) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_q <= ST_DONE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      if (fire && (WAIT_CYCLES != 0)) begin
        rdata_q <= load_val;
        err_q   <= acc_misal;
      end
    end
  end

  // Stall is gated by reset so it drops the moment reset asserts.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      StallM    = 1'b0;
      ReadDataM = (reset && req) ? load_val : '0;
      MemErrM   = reset && req && acc_misal;
    end else begin
      StallM    = reset && (((state_q == ST_IDLE) && req) || (state_q == ST_WAIT));
      ReadDataM = (state_q == ST_DONE) ? rdata_q : '0;
      MemErrM   = err_q;
    end
  end

endmodule
